resolve_noite: RTL and testbench



---
 rtl/resolve_noite.sv | 197 +++++++++++++++++++
 tb/tb_resolve_noite.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/resolve_noite.sv
// Night-action resolver: records wolf/doctor choices, resolves the kill, owns the alive mask.
// Optional feature: define BLOQUEIA_REPETE_MEDICO_EN to forbid protecting the same player twice.
module resolve_noite #(
    parameter int unsigned N_JOG = 5,
    parameter int unsigned W_JOG = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             novo_jogo_i,
    input  logic             inicia_noite_i,
    input  logic [W_JOG-1:0] jogador_i,
    input  logic [1:0]       classe_i,
    input  logic [W_JOG-1:0] alvo_i,
    input  logic             confirma_i,
    input  logic             fim_noite_i,
    output logic [N_JOG-1:0] vivos_o,
    output logic [W_JOG-1:0] morto_o,
    output logic             houve_morte_o,
    output logic             resultado_valido_o,
    output logic [2:0]       count_vivos_o,
    output logic             lobos_vencem_o,
    output logic             erro_alvo_o,
    output logic             pronto_o,
    output logic [2:0]       db_estado_o
);

    localparam int unsigned    NIdx    = 2 ** W_JOG;
    localparam logic [W_JOG-1:0] Ninguem = '1;
    localparam logic [W_JOG-1:0] NJogW   = W_JOG'(N_JOG);
    localparam logic [1:0]     ClVila  = 2'b00;
    localparam logic [1:0]     ClLobo  = 2'b01;
    localparam logic [1:0]     ClErro  = 2'b11;

    typedef enum logic [2:0] {
        StOcioso    = 3'd0,
        StColeta    = 3'd1,
        StResolve   = 3'd2,
        StResultado = 3'd3
    } estado_e;

    estado_e          state_q, state_d;
    logic [N_JOG-1:0] vivos_q, vivos_d;
    logic [W_JOG-1:0] morto_q, morto_d;
    logic             houve_morte_q, houve_morte_d;
    logic             erro_alvo_q, erro_alvo_d;
    logic [W_JOG-1:0] alvo_lobo_q, alvo_lobo_d;
    logic             lobo_ok_q, lobo_ok_d;
    logic [W_JOG-1:0] alvo_medico_q, alvo_medico_d;
    logic             medico_ok_q, medico_ok_d;
`ifdef BLOQUEIA_REPETE_MEDICO_EN
    logic [W_JOG-1:0] ult_prot_q, ult_prot_d;
`endif

    logic [NIdx-1:0] vivos_ext;
    logic            kill;

    always_comb begin
        // Zero-extended mask so out-of-range indices read as dead instead of X
        vivos_ext              = '0;
        vivos_ext[N_JOG-1:0]   = vivos_q;
        kill = lobo_ok_q && !(medico_ok_q && (alvo_medico_q == alvo_lobo_q));

        state_d       = state_q;
        vivos_d       = vivos_q;
        morto_d       = morto_q;
        houve_morte_d = houve_morte_q;
        erro_alvo_d   = 1'b0;
        alvo_lobo_d   = alvo_lobo_q;
        lobo_ok_d     = lobo_ok_q;
        alvo_medico_d = alvo_medico_q;
        medico_ok_d   = medico_ok_q;
`ifdef BLOQUEIA_REPETE_MEDICO_EN
        ult_prot_d    = ult_prot_q;
`endif

        if (novo_jogo_i) begin
            state_d       = StOcioso;
            vivos_d       = '1;
            morto_d       = Ninguem;
            houve_morte_d = 1'b0;
            alvo_lobo_d   = Ninguem;
            lobo_ok_d     = 1'b0;
            alvo_medico_d = Ninguem;
            medico_ok_d   = 1'b0;
`ifdef BLOQUEIA_REPETE_MEDICO_EN
            ult_prot_d    = Ninguem;
`endif
        end else begin
            case (state_q)
                StOcioso, StResultado: begin
                    if (inicia_noite_i) begin
                        state_d     = StColeta;
                        lobo_ok_d   = 1'b0;
                        medico_ok_d = 1'b0;
                    end
                end
                StColeta: begin
                    if (confirma_i) begin
                        if (jogador_i >= NJogW || classe_i == ClErro) begin
                            erro_alvo_d = 1'b1;
                        end else if (!vivos_ext[jogador_i] || classe_i == ClVila) begin
                            // Dead players and villagers pass their turn silently
                        end else if (alvo_i >= NJogW || !vivos_ext[alvo_i]) begin
                            erro_alvo_d = 1'b1;
                        end else if (classe_i == ClLobo) begin
                            if (alvo_i == jogador_i) begin
                                erro_alvo_d = 1'b1;
                            end else begin
                                alvo_lobo_d = alvo_i;
                                lobo_ok_d   = 1'b1;
                            end
                        end else begin
`ifdef BLOQUEIA_REPETE_MEDICO_EN
                            if (alvo_i == ult_prot_q) begin
                                erro_alvo_d = 1'b1;
                            end else begin
                                alvo_medico_d = alvo_i;
                                medico_ok_d   = 1'b1;
                            end
`else
                            alvo_medico_d = alvo_i;
                            medico_ok_d   = 1'b1;
`endif
                        end
                    end
                    if (fim_noite_i) begin
                        state_d = StResolve;
                    end
                end
                StResolve: begin
                    state_d = StResultado;
                    if (kill) begin
                        vivos_d[alvo_lobo_q] = 1'b0;
                        morto_d              = alvo_lobo_q;
                        houve_morte_d        = 1'b1;
                    end else begin
                        morto_d       = Ninguem;
                        houve_morte_d = 1'b0;
                    end
`ifdef BLOQUEIA_REPETE_MEDICO_EN
                    if (medico_ok_q) begin
                        ult_prot_d = alvo_medico_q;
                    end
`endif
                end
                default: state_d = StOcioso;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StOcioso;
            vivos_q       <= '1;
            morto_q       <= Ninguem;
            houve_morte_q <= 1'b0;
            erro_alvo_q   <= 1'b0;
            alvo_lobo_q   <= Ninguem;
            lobo_ok_q     <= 1'b0;
            alvo_medico_q <= Ninguem;
            medico_ok_q   <= 1'b0;
`ifdef BLOQUEIA_REPETE_MEDICO_EN
            ult_prot_q    <= Ninguem;
`endif
        end else begin
            state_q       <= state_d;
            vivos_q       <= vivos_d;
            morto_q       <= morto_d;
            houve_morte_q <= houve_morte_d;
            erro_alvo_q   <= erro_alvo_d;
            alvo_lobo_q   <= alvo_lobo_d;
            lobo_ok_q     <= lobo_ok_d;
            alvo_medico_q <= alvo_medico_d;
            medico_ok_q   <= medico_ok_d;
`ifdef BLOQUEIA_REPETE_MEDICO_EN
            ult_prot_q    <= ult_prot_d;
`endif
        end
    end

    always_comb begin
        count_vivos_o = '0;
        for (int i = 0; i < int'(N_JOG); i++) begin
            count_vivos_o = count_vivos_o + 3'(vivos_q[i]);
        end
    end

    assign lobos_vencem_o     = (count_vivos_o <= 3'd2);
    assign vivos_o            = vivos_q;
    assign morto_o            = morto_q;
    assign houve_morte_o      = houve_morte_q;
    assign erro_alvo_o        = erro_alvo_q;
    assign resultado_valido_o = (state_q == StResultado);
    assign pronto_o           = (state_q == StOcioso) || (state_q == StResultado);
    assign db_estado_o        = state_q;

endmodule

// File: tb/tb_resolve_noite.sv
// Directed bench for resolve_noite; expectations follow BLOQUEIA_REPETE_MEDICO_EN when defined.
module tb_resolve_noite;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       novo_jogo = 1'b0, inicia_noite = 1'b0, confirma = 1'b0, fim_noite = 1'b0;
    logic [2:0] jogador = '0, alvo = '0;
    logic [1:0] classe = '0;
    logic [4:0] vivos;
    logic [2:0] morto, count_vivos, db_estado;
    logic       houve_morte, resultado_valido, lobos_vencem, erro_alvo, pronto;

    int n_checks = 0;
    int n_errors = 0;

    resolve_noite dut (
        .clock              (clock),
        .reset              (reset),
        .novo_jogo_i        (novo_jogo),
        .inicia_noite_i     (inicia_noite),
        .jogador_i          (jogador),
        .classe_i           (classe),
        .alvo_i             (alvo),
        .confirma_i         (confirma),
        .fim_noite_i        (fim_noite),
        .vivos_o            (vivos),
        .morto_o            (morto),
        .houve_morte_o      (houve_morte),
        .resultado_valido_o (resultado_valido),
        .count_vivos_o      (count_vivos),
        .lobos_vencem_o     (lobos_vencem),
        .erro_alvo_o        (erro_alvo),
        .pronto_o           (pronto),
        .db_estado_o        (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_novo();
        novo_jogo = 1'b1; tick(); novo_jogo = 1'b0;
    endtask

    task automatic pulse_inicia();
        inicia_noite = 1'b1; tick(); inicia_noite = 1'b0;
    endtask

    task automatic conf(input logic [2:0] j, input logic [1:0] c, input logic [2:0] a);
        jogador = j; classe = c; alvo = a; confirma = 1'b1;
        tick();
        confirma = 1'b0;
    endtask

    task automatic resolve(input string tag);
        fim_noite = 1'b1; tick(); fim_noite = 1'b0;
        check_eq({tag, "_db_resolve"}, 32'(db_estado), 32'd2);
        tick();
        check_eq({tag, "_valido"}, 32'(resultado_valido), 32'd1);
    endtask

    initial begin
        #12;
        check_eq("rst_vivos", 32'(vivos), 32'h1f);
        check_eq("rst_morto", 32'(morto), 32'd7);
        check_eq("rst_db", 32'(db_estado), 32'd0);
        check_eq("rst_pronto", 32'(pronto), 32'd1);
        check_eq("rst_count", 32'(count_vivos), 32'd5);
        reset = 1'b0;
        tick();

        // Wolf 0 kills 3, doctor 1 protects self
        pulse_novo();
        pulse_inicia();
        check_eq("t2_db_coleta", 32'(db_estado), 32'd1);
        check_eq("t2_pronto", 32'(pronto), 32'd0);
        conf(3'd0, 2'b01, 3'd3);
        check_eq("t2_erro", 32'(erro_alvo), 32'd0);
        conf(3'd1, 2'b10, 3'd1);
        resolve("t2");
        check_eq("t2_morto", 32'(morto), 32'd3);
        check_eq("t2_houve", 32'(houve_morte), 32'd1);
        check_eq("t2_vivos", 32'(vivos), 32'h17);
        check_eq("t2_count", 32'(count_vivos), 32'd4);
        check_eq("t2_lobos", 32'(lobos_vencem), 32'd0);
        check_eq("t2_pronto", 32'(pronto), 32'd1);

        // Doctor saves the wolf's target
        pulse_inicia();
        check_eq("t3_valido_drop", 32'(resultado_valido), 32'd0);
        conf(3'd0, 2'b01, 3'd2);
        conf(3'd1, 2'b10, 3'd2);
        resolve("t3");
        check_eq("t3_houve", 32'(houve_morte), 32'd0);
        check_eq("t3_morto", 32'(morto), 32'd7);
        check_eq("t3_vivos", 32'(vivos), 32'h17);

        // Rejected and ignored confirmations
        pulse_inicia();
        conf(3'd0, 2'b01, 3'd0);
        check_eq("t4_self", 32'(erro_alvo), 32'd1);
        tick();
        check_eq("t4_pulse_end", 32'(erro_alvo), 32'd0);
        conf(3'd0, 2'b01, 3'd5);
        check_eq("t4_alvo5", 32'(erro_alvo), 32'd1);
        conf(3'd0, 2'b01, 3'd3);
        check_eq("t4_alvo_dead", 32'(erro_alvo), 32'd1);
        conf(3'd7, 2'b01, 3'd1);
        check_eq("t4_jog_inv", 32'(erro_alvo), 32'd1);
        conf(3'd1, 2'b11, 3'd0);
        check_eq("t4_classe_err", 32'(erro_alvo), 32'd1);
        conf(3'd3, 2'b01, 3'd1);
        check_eq("t4_dead_jog", 32'(erro_alvo), 32'd0);
        conf(3'd2, 2'b00, 3'd1);
        check_eq("t4_villager", 32'(erro_alvo), 32'd0);
        resolve("t4");
        check_eq("t4_houve", 32'(houve_morte), 32'd0);
        check_eq("t4_vivos", 32'(vivos), 32'h17);
        conf(3'd0, 2'b01, 3'd1);
        check_eq("t4_conf_resultado", 32'(erro_alvo), 32'd0);
        fim_noite = 1'b1; tick(); fim_noite = 1'b0;
        check_eq("t4_fim_ignored", 32'(db_estado), 32'd3);

        // confirma together with fim_noite, then a last-wins night
        pulse_inicia();
        jogador = 3'd0; classe = 2'b01; alvo = 3'd4; confirma = 1'b1; fim_noite = 1'b1;
        tick();
        confirma = 1'b0; fim_noite = 1'b0;
        tick();
        check_eq("t5_morto4", 32'(morto), 32'd4);
        check_eq("t5_vivos", 32'(vivos), 32'h07);
        pulse_inicia();
        conf(3'd0, 2'b01, 3'd1);
        conf(3'd0, 2'b01, 3'd2);
        resolve("t5b");
        check_eq("t5_morto2", 32'(morto), 32'd2);
        check_eq("t5_vivos2", 32'(vivos), 32'h03);
        check_eq("t5_count", 32'(count_vivos), 32'd2);
        check_eq("t5_lobos", 32'(lobos_vencem), 32'd1);

        // Async reset in the middle of COLETA
        pulse_inicia();
        conf(3'd0, 2'b01, 3'd1);
        reset = 1'b1;
        #1;
        check_eq("t1_vivos", 32'(vivos), 32'h1f);
        check_eq("t1_morto", 32'(morto), 32'd7);
        check_eq("t1_houve", 32'(houve_morte), 32'd0);
        check_eq("t1_valido", 32'(resultado_valido), 32'd0);
        check_eq("t1_db", 32'(db_estado), 32'd0);
        check_eq("t1_pronto", 32'(pronto), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        // Doctor repeats the same protection on consecutive nights
        pulse_inicia();
        conf(3'd1, 2'b10, 3'd2);
        conf(3'd0, 2'b01, 3'd3);
        resolve("t6a");
        check_eq("t6_morto3", 32'(morto), 32'd3);
        pulse_inicia();
        conf(3'd1, 2'b10, 3'd2);
`ifdef BLOQUEIA_REPETE_MEDICO_EN
        check_eq("t6_erro_repete", 32'(erro_alvo), 32'd1);
`else
        check_eq("t6_erro_repete", 32'(erro_alvo), 32'd0);
`endif
        conf(3'd0, 2'b01, 3'd2);
        resolve("t6b");
`ifdef BLOQUEIA_REPETE_MEDICO_EN
        check_eq("t6_morto", 32'(morto), 32'd2);
        check_eq("t6_houve", 32'(houve_morte), 32'd1);
        check_eq("t6_vivos", 32'(vivos), 32'h13);
`else
        check_eq("t6_morto", 32'(morto), 32'd7);
        check_eq("t6_houve", 32'(houve_morte), 32'd0);
        check_eq("t6_vivos", 32'(vivos), 32'h17);
`endif

        // novo_jogo wins over a same-cycle confirma
        pulse_inicia();
        jogador = 3'd0; classe = 2'b01; alvo = 3'd1; confirma = 1'b1; novo_jogo = 1'b1;
        tick();
        confirma = 1'b0; novo_jogo = 1'b0;
        check_eq("nj_db", 32'(db_estado), 32'd0);
        check_eq("nj_vivos", 32'(vivos), 32'h1f);
        check_eq("nj_morto", 32'(morto), 32'd7);
        check_eq("nj_houve", 32'(houve_morte), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
